pwm_fader: RTL and testbench

Multi-channel PWM generator with a built-in prescaler, glitch-free period-boundary duty updates and an optional linear fade (ramp) mode. It replaces per-colour fixed-duty PWM instances: one block drives `CHANNELS` outputs (e.g. RGB LEDs) with `RES`-bit duty resolution from a single shared prescaler and period counter. It sits between the switch/register front-end (which supplies targets) and the LED pins.

---
 rtl/pwm_fader.sv | 85 ++++++++
 tb/tb_pwm_fader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_fader.sv
// pwm_fader: multi-channel PWM with a shared prescaler and period counter, boundary-synchronous
// duty updates and an optional linear fade toward the captured targets.
module pwm_fader #(
    parameter int CHANNELS    = 3,
    parameter int RES         = 8,
    parameter int PRESC_WIDTH = 12
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [PRESC_WIDTH-1:0]   limit,
    input  logic                     fade_en,
    input  logic [7:0]               fade_rate,
    input  logic [CHANNELS*RES-1:0]  target,
    input  logic                     load,
    output logic [CHANNELS-1:0]      pwm,
    output logic [CHANNELS*RES-1:0]  duty,
    output logic [CHANNELS-1:0]      busy,
    output logic                     period_start
);
    logic [PRESC_WIDTH-1:0]  pc_q, pc_d;
    logic [RES-1:0]          cnt_q, cnt_d;
    logic [7:0]              step_q, step_d;
    logic [CHANNELS*RES-1:0] tgt_q, tgt_d, active_q, active_d;
    logic [CHANNELS-1:0]     pwm_q, pwm_d;
    logic                    period_start_q, period_start_d;
    logic                    tick, boundary, step;
    logic [7:0]              rate;
    logic [RES-1:0]          a, t;

    always_comb begin
        // >= lets the prescaler recover at once when limit drops below the current count
        tick = (limit <= PRESC_WIDTH'(1)) || (pc_q >= limit - PRESC_WIDTH'(1));
        pc_d = tick ? '0 : pc_q + PRESC_WIDTH'(1);
        cnt_d = tick ? cnt_q + RES'(1) : cnt_q;
        boundary = tick && (cnt_q == '1);
        period_start_d = boundary;
        rate = (fade_rate == 8'd0) ? 8'd1 : fade_rate;
        step = boundary && fade_en && ({1'b0, step_q} + 9'd1 >= {1'b0, rate});
        step_d = !boundary ? step_q : (!fade_en || step) ? 8'd0 : step_q + 8'd1;
        tgt_d = load ? target : tgt_q;
    end

    always_comb begin
        active_d = active_q;
        pwm_d = '0;
        busy = '0;
        a = '0;
        t = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            a = active_q[i*RES +: RES];
            t = tgt_q[i*RES +: RES];
            active_d[i*RES +: RES] = !boundary ? a :
                                     !fade_en  ? t :
                                     !step     ? a :
                                     (a < t)   ? a + RES'(1) :
                                     (a > t)   ? a - RES'(1) : a;
            pwm_d[i] = cnt_q < a;
            busy[i] = a != t;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q           <= '0;
            cnt_q          <= '0;
            step_q         <= '0;
            tgt_q          <= '0;
            active_q       <= '0;
            pwm_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            pc_q           <= pc_d;
            cnt_q          <= cnt_d;
            step_q         <= step_d;
            tgt_q          <= tgt_d;
            active_q       <= active_d;
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
        end
    end

    assign pwm          = pwm_q;
    assign duty         = active_q;
    assign period_start = period_start_q;
endmodule

// File: tb/tb_pwm_fader.sv
// tb_pwm_fader: scoreboard bench for pwm_fader with CHANNELS=3, RES=4, limit=2 (32-clock period).
module tb_pwm_fader;
    localparam int CH  = 3;
    localparam int RES = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [11:0]       limit = 12'd2;
    logic              fade_en = 1'b0;
    logic [7:0]        fade_rate = 8'd0;
    logic [CH*RES-1:0] target = '0;
    logic              load = 1'b0;
    logic [CH-1:0]     pwm, busy;
    logic [CH*RES-1:0] duty;
    logic              period_start;
    logic              mon_en = 1'b1;
    int                checks = 0;
    int                errors = 0;
    int                n;

    typedef struct {
        logic [CH*RES-1:0] duty;
        logic [CH-1:0]     busy;
        bit                chk;
        int                p0, p1, p2;
    } exp_t;
    exp_t sb[$];

    pwm_fader #(.CHANNELS(CH), .RES(RES), .PRESC_WIDTH(12)) dut (
        .clock(clock), .reset(reset), .limit(limit), .fade_en(fade_en),
        .fade_rate(fade_rate), .target(target), .load(load), .pwm(pwm),
        .duty(duty), .busy(busy), .period_start(period_start)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // expected state right after a boundary; p0/p2 are pwm high counts over the period it closes
    task automatic push(input logic [11:0] d, input logic [2:0] b, input bit c, input int p0, input int p2);
        exp_t e;
        e.duty = d;
        e.busy = b;
        e.chk = c;
        e.p0 = p0;
        e.p1 = 0;
        e.p2 = p2;
        sb.push_back(e);
    endtask

    task automatic do_load(input logic [11:0] v);
        @(negedge clock);
        load = 1'b1;
        target = v;
        @(negedge clock);
        load = 1'b0;
    endtask

    task automatic wait_b();
        int k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!period_start && k < 200);
        if (!period_start) begin
            checks++;
            errors++;
            $display("FAIL boundary_timeout got no period_start expected one within 200 clocks");
        end
    endtask

    task automatic count_gap(output int g);
        g = 0;
        do begin
            @(negedge clock);
            g++;
        end while (!period_start && g < 200);
    endtask

    initial begin : monitor
        int hc[CH];
        int bn;
        exp_t e;
        bn = 0;
        hc = '{default: 0};
        forever begin
            @(negedge clock);
            if (reset || !mon_en) begin
                hc = '{default: 0};
                continue;
            end
            if (period_start) begin
                bn++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b%0d_unexpected got boundary expected none", bn);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("b%0d_duty", bn), int'(duty), int'(e.duty));
                    check($sformatf("b%0d_busy", bn), int'(busy), int'(e.busy));
                    if (e.chk) begin
                        check($sformatf("b%0d_pwm0_cnt", bn), hc[0], e.p0);
                        check($sformatf("b%0d_pwm1_cnt", bn), hc[1], e.p1);
                        check($sformatf("b%0d_pwm2_cnt", bn), hc[2], e.p2);
                    end
                end
                hc = '{default: 0};
            end
            for (int i = 0; i < CH; i++) hc[i] += int'(pwm[i]);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got no finish expected finish before 100us");
        $fatal(1);
    end

    initial begin
        #1 reset = 1'b1;
        #1;
        check("rst0_pwm", int'(pwm), 0);
        check("rst0_duty", int'(duty), 0);
        check("rst0_busy", int'(busy), 0);
        check("rst0_ps", int'(period_start), 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // direct mode
        do_load(12'hF08);
        push(12'hF08, 3'b000, 1'b0, 0, 0);
        push(12'hF08, 3'b000, 1'b1, 16, 30);
        push(12'hF08, 3'b000, 1'b1, 16, 30);
        repeat (3) wait_b();

        // deferred update, last load wins
        repeat (5) @(negedge clock);
        do_load(12'hF04);
        check("defer1_duty", int'(duty), 'hF08);
        check("defer1_busy", int'(busy), 'b001);
        repeat (5) @(negedge clock);
        do_load(12'hF0C);
        check("defer2_duty", int'(duty), 'hF08);
        check("defer2_busy", int'(busy), 'b001);
        push(12'hF0C, 3'b000, 1'b1, 16, 30);
        wait_b();
        push(12'hF0C, 3'b000, 1'b1, 24, 30);
        wait_b();
        do_load(12'hF00);
        push(12'hF00, 3'b000, 1'b1, 24, 30);
        wait_b();

        // fade up 0 -> 3 at rate 2, then down to 0
        fade_en = 1'b1;
        fade_rate = 8'd2;
        do_load(12'hF03);
        push(12'hF00, 3'b001, 1'b1, 0, 30);
        push(12'hF01, 3'b001, 1'b1, 0, 30);
        push(12'hF01, 3'b001, 1'b1, 2, 30);
        push(12'hF02, 3'b001, 1'b1, 2, 30);
        push(12'hF02, 3'b001, 1'b1, 4, 30);
        push(12'hF03, 3'b000, 1'b1, 4, 30);
        repeat (6) wait_b();
        do_load(12'hF00);
        push(12'hF03, 3'b001, 1'b1, 6, 30);
        push(12'hF02, 3'b001, 1'b1, 6, 30);
        push(12'hF02, 3'b001, 1'b1, 4, 30);
        push(12'hF01, 3'b001, 1'b1, 4, 30);
        push(12'hF01, 3'b001, 1'b1, 2, 30);
        push(12'hF00, 3'b000, 1'b1, 2, 30);
        push(12'hF00, 3'b000, 1'b1, 0, 30);
        push(12'hF00, 3'b000, 1'b1, 0, 30);
        repeat (8) wait_b();

        // abort mid-ramp: jump straight to target
        do_load(12'hF0A);
        push(12'hF00, 3'b001, 1'b1, 0, 30);
        push(12'hF01, 3'b001, 1'b1, 0, 30);
        repeat (2) wait_b();
        repeat (5) @(negedge clock);
        fade_en = 1'b0;
        push(12'hF0A, 3'b000, 1'b1, 2, 30);
        wait_b();

        // fade_rate 0 steps every period
        fade_rate = 8'd0;
        fade_en = 1'b1;
        do_load(12'hF07);
        push(12'hF09, 3'b001, 1'b1, 20, 30);
        push(12'hF08, 3'b001, 1'b1, 18, 30);
        push(12'hF07, 3'b000, 1'b1, 16, 30);
        push(12'hF07, 3'b000, 1'b1, 14, 30);
        repeat (4) wait_b();
        check("sb_drain", sb.size(), 0);
        mon_en = 1'b0;

        // limit change: cnt=15 so the next tick is visible as period_start
        repeat (30) @(negedge clock);
        limit = 12'd10;
        for (int k = 0; k < 7; k++) begin
            @(negedge clock);
            check($sformatf("no_tick_lim10_%0d", k), int'(period_start), 0);
        end
        limit = 12'd2;
        @(negedge clock);
        check("tick_after_lim_drop", int'(period_start), 1);
        count_gap(n);
        check("gap_lim2", n, 32);
        limit = 12'd0;
        count_gap(n);
        check("gap_lim0", n, 16);
        limit = 12'd2;

        // async reset during a boundary cycle, mid-ramp
        do_load(12'hF0F);
        wait_b();
        #2 reset = 1'b1;
        #1;
        check("rst1_ps", int'(period_start), 0);
        check("rst1_duty", int'(duty), 0);
        check("rst1_busy", int'(busy), 0);
        check("rst1_pwm", int'(pwm), 0);
        @(negedge clock);
        reset = 1'b0;

        // async reset while pwm outputs are high
        do_load(12'hF0F);
        wait_b();
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("rst2_pwm", int'(pwm), 0);
        check("rst2_duty", int'(duty), 0);
        check("rst2_busy", int'(busy), 0);
        @(negedge clock);
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
